// File: rtl/dram_perf_pkg.sv
// Shared types and constants for the DRAM write-bandwidth traffic generator.
// calc_beats sizes each burst so it never runs past a 4 KB boundary.
package dram_perf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_64B   = 3'b110;
    localparam int         BEAT_BYTES     = 64;

    // Result is always 1..max_beats when remaining != 0 and addr is beat aligned.
    function automatic logic [6:0] calc_beats(input logic [31:0] remaining,
                                              input logic [31:0] addr,
                                              input logic [6:0]  max_beats);
        logic [12:0] to_4k;
        logic [31:0] beats;
        to_4k = (13'd4096 - {1'b0, addr[11:0]}) >> 6;
        beats = remaining;
        if ({25'd0, max_beats} < beats) beats = {25'd0, max_beats};
        if ({19'd0, to_4k} < beats)     beats = {19'd0, to_4k};
        return beats[6:0];
    endfunction

endpackage

// File: rtl/dram_wr_traffic_gen.sv
// AXI4 write traffic generator: one burst outstanding at a time, AW then W then B,
// with busy/done/err status and a saturating busy-cycle counter.
module dram_wr_traffic_gen
    import dram_perf_pkg::*;
#(
    parameter int DATA_W    = 512,
    parameter int MAX_BURST = 64,
    parameter int AXI_ID    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [31:0]         start_addr,
    input  logic [31:0]         burst_len,
    input  logic [31:0]         write_val,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [31:0]         cycle_cnt,
    output logic [15:0]         awid,
    output logic [63:0]         awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [15:0]         bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output state_e              dbg_state_o
);

    localparam logic [6:0] MAX_BEATS = 7'(MAX_BURST);
    localparam int         REPL      = DATA_W / 32;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid and its payload hold steady until that edge.
    state_e      state_q, state_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] val_q, val_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  awlen_q, awlen_d;
    logic [7:0]  beat_q, beat_d;

    logic [31:0] burst_beats;
    logic [31:0] addr_after;
    logic [31:0] rem_after;
    logic [6:0]  beats_launch;
    logic [6:0]  beats_next;
    logic        unused_bid;

    assign burst_beats  = 32'(awlen_q) + 32'd1;
    assign addr_after   = addr_q + (burst_beats << 6);
    assign rem_after    = rem_q - burst_beats;
    assign beats_launch = calc_beats(rem_q, addr_q, MAX_BEATS);
    assign beats_next   = calc_beats(rem_after, addr_after, MAX_BEATS);
    assign unused_bid   = ^bid;

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        err_d   = err_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        val_d   = val_q;
        cnt_d   = cnt_q;
        awlen_d = awlen_q;
        beat_d  = beat_q;

        if ((busy_q || state_q == ST_DONE) && cnt_q != 32'hFFFF_FFFF)
            cnt_d = cnt_q + 32'd1;

        case (state_q)
            ST_IDLE: begin
                // busy_q in IDLE marks the launch cycle right after an accepted start.
                if (!busy_q) begin
                    if (start) begin
                        addr_d = {start_addr[31:6], 6'b0};
                        rem_d  = burst_len;
                        val_d  = write_val;
                        err_d  = 1'b0;
                        cnt_d  = 32'd0;
                        busy_d = 1'b1;
                    end
                end else if (rem_q == 32'd0) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_AW;
                    awlen_d = {1'b0, beats_launch - 7'd1};
                    beat_d  = 8'd0;
                end
            end
            ST_AW: begin
                if (awready) state_d = ST_W;
            end
            ST_W: begin
                if (wready) begin
                    beat_d = beat_q + 8'd1;
                    if (beat_q == awlen_q) state_d = ST_B;
                end
            end
            ST_B: begin
                if (bvalid) begin
                    if (bresp != AXI_RESP_OKAY) err_d = 1'b1;
                    addr_d = addr_after;
                    rem_d  = rem_after;
                    if (rem_after != 32'd0) begin
                        state_d = ST_AW;
                        awlen_d = {1'b0, beats_next - 7'd1};
                        beat_d  = 8'd0;
                    end else begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= 32'd0;
            rem_q   <= 32'd0;
            val_q   <= 32'd0;
            cnt_q   <= 32'd0;
            awlen_q <= 8'd0;
            beat_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            val_q   <= val_d;
            cnt_q   <= cnt_d;
            awlen_q <= awlen_d;
            beat_q  <= beat_d;
        end
    end

    // Static AXI attributes are gated by their valid so every output reads 0 in reset.
    assign busy        = busy_q;
    assign done        = (state_q == ST_DONE);
    assign err         = err_q;
    assign cycle_cnt   = cnt_q;
    assign awid        = 16'(AXI_ID);
    assign awaddr      = {32'd0, addr_q};
    assign awlen       = awlen_q;
    assign awvalid     = (state_q == ST_AW);
    assign awsize      = awvalid ? AXI_SIZE_64B : 3'b000;
    assign awburst     = awvalid ? AXI_BURST_INCR : 2'b00;
    assign wvalid      = (state_q == ST_W);
    assign wdata       = {REPL{val_q}};
    assign wstrb       = {(DATA_W/8){wvalid}};
    assign wlast       = wvalid && (beat_q == awlen_q);
    assign bready      = (state_q == ST_B);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dram_wr_traffic_gen.sv
// Self-checking bench for dram_wr_traffic_gen: table of runs plus reset and stray-response
// sequences, with AW and W scoreboards filled from a burst-splitting model.
module tb_dram_wr_traffic_gen;
    import dram_perf_pkg::*;

    localparam int DATA_W = 512;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [31:0]         start_addr, burst_len, write_val;
    logic                busy, done, err;
    logic [31:0]         cycle_cnt;
    logic [15:0]         awid;
    logic [63:0]         awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid, awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast, wvalid, wready;
    logic [15:0]         bid;
    logic [1:0]          bresp;
    logic                bvalid, bready;
    state_e              dbg_state;

    always #5 clk = ~clk;

    dram_wr_traffic_gen #(.DATA_W(DATA_W), .MAX_BURST(64), .AXI_ID(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .burst_len(burst_len), .write_val(write_val), .busy(busy), .done(done),
        .err(err), .cycle_cnt(cycle_cnt), .awid(awid), .awaddr(awaddr),
        .awlen(awlen), .awsize(awsize), .awburst(awburst), .awvalid(awvalid),
        .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp),
        .bvalid(bvalid), .bready(bready), .dbg_state_o(dbg_state)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] len;
        logic [31:0] val;
        bit          stall;
        int          slverr_at;
        bit          mid_start;
        int          n_aw;
        int          n_beats;
        bit          exp_err;
        int          done_lat;
    } vec_t;

    vec_t vecs[9];

    logic [39:0] exp_aw_q[$];
    logic [32:0] exp_w_q[$];

    int n_cmp = 0;
    int n_fail = 0;

    bit                stall;
    int                slverr_at, b_idx, pend_b;
    bit                b_hs, aw_hold, w_hold;
    logic [63:0]       aw_prev_addr;
    logic [7:0]        aw_prev_len;
    logic [DATA_W-1:0] w_prev_data;
    logic              w_prev_last;
    int                aw_hs, w_hs, busy_cycles, done_cnt;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reset_sb();
        exp_aw_q.delete();
        exp_w_q.delete();
        b_idx = 0; pend_b = 0; b_hs = 0;
        aw_hold = 0; w_hold = 0;
        aw_hs = 0; w_hs = 0; busy_cycles = 0; done_cnt = 0;
        bvalid = 1'b0; bresp = 2'b00;
    endtask

    // Reference burst splitter: min(remaining, 64, beats left in the 4 KB page).
    task automatic push_expected(input logic [31:0] addr, input logic [31:0] len, input logic [31:0] val);
        logic [31:0] a, rem, b, to4k;
        a = {addr[31:6], 6'b0};
        rem = len;
        while (rem != 0) begin
            to4k = (32'd4096 - {20'd0, a[11:0]}) / 32'd64;
            b = rem;
            if (b > 32'd64) b = 32'd64;
            if (b > to4k) b = to4k;
            exp_aw_q.push_back({a, 8'(b - 1)});
            for (int i = 0; i < int'(b); i++) exp_w_q.push_back({(i == int'(b) - 1), val});
            a = a + b * 32'd64;
            rem = rem - b;
        end
    endtask

    task automatic drive_resp();
        if (b_hs) begin
            bvalid = 1'b0; bresp = 2'b00; b_hs = 0;
        end
        if (!bvalid && pend_b > 0) begin
            b_idx++;
            pend_b--;
            bvalid = 1'b1;
            bresp = (b_idx == slverr_at) ? 2'b10 : 2'b00;
        end
        awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic monitor();
        logic [39:0]       ea;
        logic [32:0]       ew;
        logic [31:0]       wv;
        logic [DATA_W-1:0] exp_data;
        if (busy || done) busy_cycles++;
        if (done) done_cnt++;
        if (awvalid && wvalid) check(0, "aw_w_overlap", 64'd1, 64'd0);
        if (aw_hold)
            check(awvalid && awaddr == aw_prev_addr && awlen == aw_prev_len, "aw_stable",
                  {awaddr[31:0], 24'd0, awlen}, {aw_prev_addr[31:0], 24'd0, aw_prev_len});
        if (awvalid && awready) begin
            aw_hs++;
            if (exp_aw_q.size() == 0) check(0, "aw_extra", awaddr, 64'd0);
            else begin
                ea = exp_aw_q.pop_front();
                check(awaddr == {32'd0, ea[39:8]} && awlen == ea[7:0] && awsize == 3'b110
                      && awburst == 2'b01 && awid == 16'd0, "aw_beat",
                      {awaddr[31:0], 24'd0, awlen}, {ea[39:8], 24'd0, ea[7:0]});
            end
        end
        aw_hold = awvalid && !awready;
        aw_prev_addr = awaddr; aw_prev_len = awlen;
        if (w_hold)
            check(wvalid && wdata == w_prev_data && wlast == w_prev_last, "w_stable",
                  {31'd0, wlast, wdata[31:0]}, {31'd0, w_prev_last, w_prev_data[31:0]});
        if (wvalid && wready) begin
            w_hs++;
            if (exp_w_q.size() == 0) check(0, "w_extra", {31'd0, wlast, wdata[31:0]}, 64'd0);
            else begin
                ew = exp_w_q.pop_front();
                wv = ew[31:0];
                exp_data = {16{wv}};
                check(wdata == exp_data && wlast == ew[32] && wstrb == {(DATA_W/8){1'b1}}, "w_beat",
                      {31'd0, wlast, wdata[31:0]}, {31'd0, ew[32], ew[31:0]});
            end
            if (wlast) pend_b++;
        end
        w_hold = wvalid && !wready;
        w_prev_data = wdata; w_prev_last = wlast;
        if (bvalid && bready) b_hs = 1;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        drive_resp();
        @(negedge clk);
        monitor();
    endtask

    task automatic zero_check(input string tag);
        check(!busy && !done && !err, {tag, "_status"}, {61'd0, busy, done, err}, 64'd0);
        check(cycle_cnt == 32'd0, {tag, "_cycle_cnt"}, {32'd0, cycle_cnt}, 64'd0);
        check(!awvalid && !wvalid && !wlast && !bready, {tag, "_valids"},
              {60'd0, awvalid, wvalid, wlast, bready}, 64'd0);
        check(awaddr == 64'd0 && awlen == 8'd0 && awsize == 3'd0 && awburst == 2'd0 && awid == 16'd0,
              {tag, "_aw_fields"}, awaddr, 64'd0);
        check(wdata == '0 && wstrb == '0, {tag, "_w_fields"}, wdata[63:0], 64'd0);
    endtask

    task automatic run_case(input vec_t v, input int idx);
        int cyc, lat;
        reset_sb();
        stall = v.stall;
        slverr_at = v.slverr_at;
        push_expected(v.addr, v.len, v.val);
        start_addr = v.addr; burst_len = v.len; write_val = v.val;
        start = 1'b1;
        cycle();
        start = 1'b0;
        lat = 1;
        cyc = 0;
        while (done_cnt == 0 && cyc < 3000) begin
            if (v.mid_start && cyc == 5) begin
                start = 1'b1; start_addr = 32'hDEAD_0000; burst_len = 32'd7; write_val = 32'd0;
            end
            cycle();
            start = 1'b0;
            cyc++;
            lat++;
        end
        check(done_cnt == 1, $sformatf("case%0d_done_seen", idx), 64'(done_cnt), 64'd1);
        if (v.done_lat != 0)
            check(lat == v.done_lat, $sformatf("case%0d_done_latency", idx), 64'(lat), 64'(v.done_lat));
        cycle();
        check(!done && !busy && done_cnt == 1, $sformatf("case%0d_done_pulse", idx),
              {62'd0, done, busy}, 64'd0);
        check(cycle_cnt == 32'(busy_cycles), $sformatf("case%0d_cycle_cnt", idx),
              {32'd0, cycle_cnt}, 64'(busy_cycles));
        check(err == v.exp_err, $sformatf("case%0d_err", idx), {63'd0, err}, {63'd0, v.exp_err});
        check(aw_hs == v.n_aw, $sformatf("case%0d_aw_count", idx), 64'(aw_hs), 64'(v.n_aw));
        check(w_hs == v.n_beats, $sformatf("case%0d_beat_count", idx), 64'(w_hs), 64'(v.n_beats));
        check(exp_aw_q.size() == 0 && exp_w_q.size() == 0, $sformatf("case%0d_sb_empty", idx),
              64'(exp_aw_q.size()), 64'(exp_w_q.size()));
    endtask

    initial begin
        vecs[0] = '{32'h0000_1000, 32'd4,   32'hA5A5_0000, 1'b0, 0, 1'b0, 1, 4,   1'b0, 0};
        vecs[1] = '{32'h0000_0000, 32'd130, 32'h1234_5678, 1'b0, 0, 1'b0, 3, 130, 1'b0, 0};
        vecs[2] = '{32'h0000_0FC0, 32'd3,   32'hCAFE_0003, 1'b0, 0, 1'b0, 2, 3,   1'b0, 0};
        vecs[3] = '{32'h0000_2000, 32'd64,  32'h5A5A_0044, 1'b1, 0, 1'b0, 1, 64,  1'b0, 0};
        vecs[4] = '{32'h0000_0000, 32'd128, 32'h0000_0128, 1'b0, 2, 1'b0, 2, 128, 1'b1, 0};
        vecs[5] = '{32'h0000_3000, 32'd0,   32'h0000_0000, 1'b0, 0, 1'b0, 0, 0,   1'b0, 2};
        vecs[6] = '{32'h0000_1234, 32'd5,   32'h7777_1234, 1'b0, 0, 1'b1, 1, 5,   1'b0, 0};
        vecs[7] = '{32'hFFFF_FFC0, 32'd2,   32'hFEED_BEEF, 1'b0, 0, 1'b0, 2, 2,   1'b0, 0};
        vecs[8] = '{32'h0000_5F80, 32'd100, 32'h0101_0101, 1'b1, 0, 1'b0, 3, 100, 1'b0, 0};

        rst_n = 1'b0;
        start = 1'b0; start_addr = '0; burst_len = '0; write_val = '0;
        awready = 1'b0; wready = 1'b0; bid = 16'd0; bresp = 2'b00; bvalid = 1'b0;
        stall = 0; slverr_at = 0;
        reset_sb();
        repeat (3) @(negedge clk);
        zero_check("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_case(vecs[i], i);

        // Response arriving while idle must not touch err.
        bvalid = 1'b1; bresp = 2'b10;
        @(negedge clk);
        @(negedge clk);
        bvalid = 1'b0; bresp = 2'b00;
        @(negedge clk);
        check(err == 1'b0 && !busy, "stray_bresp", {62'd0, err, busy}, 64'd0);

        // Asynchronous reset in the middle of a data phase, then a normal run.
        reset_sb();
        stall = 0; slverr_at = 0;
        push_expected(32'h0000_4000, 32'd8, 32'h0BAD_F00D);
        start_addr = 32'h0000_4000; burst_len = 32'd8; write_val = 32'h0BAD_F00D;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 50 && w_hs < 2; i++) cycle();
        check(wvalid == 1'b1 && w_hs >= 2, "midw_reached", {63'd0, wvalid}, 64'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 zero_check("async_reset");
        repeat (2) @(negedge clk);
        reset_sb();
        rst_n = 1'b1;
        @(negedge clk);
        run_case(vecs[0], 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
